// File: rtl/serial_rx_frame.sv
// Serial frame receiver (start, DATA_BITS LSB-first, optional parity, stop); word ready one cycle after stop sample.
// Backpressure: holding register keeps its word while out_valid && !out_ready; a good frame arriving then is dropped with overrun.
module serial_rx_frame #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
);

   localparam int H  = (CLKS_PER_BIT - 1) / 2;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] N_M1       = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] H_M1       = CW'((H > 0) ? H - 1 : 0);
   localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);
   localparam logic          PEN        = (PARITY_EN != 0);
   localparam logic          PODD       = (PARITY_ODD != 0);
   localparam logic          SKIP_START = (H == 0);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
   } state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt, shreg_in;
   logic [DATA_BITS-1:0] out_data_nxt;
   logic                 par_acc, par_acc_nxt;
   logic                 out_valid_nxt, busy_nxt;
   logic                 frame_err_nxt, parity_err_nxt, overrun_nxt;
   logic                 smp, par_ok, good;

   // cnt counts down to the next sample edge of the current bit
   assign smp    = (cnt == '0);
   assign par_ok = (par_acc == PODD);
   assign good   = rx && (!PEN || par_ok);

   generate
      if (DATA_BITS == 1) begin : g_shift1
         assign shreg_in = rx;
      end else begin : g_shiftn
         assign shreg_in = {rx, shreg[DATA_BITS-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (!rx) state_nxt = SKIP_START ? DATA : START;
         START:     if (smp) state_nxt = rx ? IDLE : DATA;
         DATA:      if (smp && (bit_cnt == LAST_BIT)) state_nxt = PEN ? PARITY : STOP;
         PARITY:    if (smp) state_nxt = STOP;
         STOP:      if (smp) state_nxt = rx ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (rx) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cnt_nxt        = cnt;
      bit_cnt_nxt    = bit_cnt;
      shreg_nxt      = shreg;
      par_acc_nxt    = par_acc;
      out_data_nxt   = out_data;
      out_valid_nxt  = out_valid && !out_ready;
      frame_err_nxt  = 1'b0;
      parity_err_nxt = 1'b0;
      overrun_nxt    = 1'b0;
      busy_nxt       = (state_nxt != IDLE);

      if (state == START || state == DATA || state == PARITY || state == STOP) begin
         cnt_nxt = smp ? N_M1 : cnt - 1'b1;
      end

      case (state)
         IDLE: begin
            if (!rx) begin
               // with H==0 the detecting edge doubles as the start verify
               cnt_nxt     = SKIP_START ? N_M1 : H_M1;
               bit_cnt_nxt = '0;
               par_acc_nxt = 1'b0;
            end
         end
         DATA: begin
            if (smp) begin
               shreg_nxt   = shreg_in;
               par_acc_nxt = par_acc ^ rx;
               bit_cnt_nxt = bit_cnt + 1'b1;
            end
         end
         PARITY: begin
            if (smp) par_acc_nxt = par_acc ^ rx;
         end
         STOP: begin
            if (smp) begin
               frame_err_nxt  = !rx;
               parity_err_nxt = PEN && !par_ok;
               if (good) begin
                  if (!out_valid || out_ready) begin
                     out_data_nxt  = shreg;
                     out_valid_nxt = 1'b1;
                  end else begin
                     overrun_nxt   = 1'b1;
                     out_valid_nxt = 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_acc    <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         bit_cnt    <= bit_cnt_nxt;
         shreg      <= shreg_nxt;
         par_acc    <= par_acc_nxt;
         out_data   <= out_data_nxt;
         out_valid  <= out_valid_nxt;
         busy       <= busy_nxt;
         frame_err  <= frame_err_nxt;
         parity_err <= parity_err_nxt;
         overrun    <= overrun_nxt;
      end
   end

endmodule

// File: tb/tb_serial_rx_frame.sv
// Directed bench: u_a is the 4-bit / 1 clk-per-bit / no-parity build, u_b the 8-bit / 4 clk-per-bit / even-parity build.
module tb_serial_rx_frame;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_a, rx_b;
   logic       ready_a, ready_b;
   logic [3:0] data_a;
   logic [7:0] data_b;
   logic       valid_a, busy_a, fe_a, pe_a, ov_a;
   logic       valid_b, busy_b, fe_b, pe_b, ov_b;

   int n_checks = 0;
   int n_errors = 0;
   int cnt_fe_a = 0, cnt_pe_a = 0, cnt_ov_a = 0, cnt_vld_a = 0;
   int cnt_fe_b = 0, cnt_pe_b = 0, cnt_ov_b = 0;
   int base_a, base_b, base_v, base_fe, base_pe, base_ov;

   always #5 clk = ~clk;

   serial_rx_frame #(.DATA_BITS(4), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_a (
      .clk(clk), .rst_n(rst_n), .rx(rx_a), .out_data(data_a), .out_valid(valid_a),
      .out_ready(ready_a), .busy(busy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));

   serial_rx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
      .clk(clk), .rst_n(rst_n), .rx(rx_b), .out_data(data_b), .out_valid(valid_b),
      .out_ready(ready_b), .busy(busy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));

   // one-cycle pulses are counted once each at the falling edge
   always @(negedge clk) begin
      if (fe_a)    cnt_fe_a++;
      if (pe_a)    cnt_pe_a++;
      if (ov_a)    cnt_ov_a++;
      if (valid_a) cnt_vld_a++;
      if (fe_b)    cnt_fe_b++;
      if (pe_b)    cnt_pe_b++;
      if (ov_b)    cnt_ov_b++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit sel_b, input logic b, input int cycles);
      if (sel_b) rx_b = b;
      else       rx_a = b;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [3:0] w);
      drive(1'b0, 1'b0, 1);
      for (int i = 0; i < 4; i++) drive(1'b0, w[i], 1);
      drive(1'b0, 1'b1, 1);
   endtask

   task automatic send_b(input logic [7:0] w, input logic pbit);
      drive(1'b1, 1'b0, 4);
      for (int i = 0; i < 8; i++) drive(1'b1, w[i], 4);
      drive(1'b1, pbit, 4);
      drive(1'b1, 1'b1, 4);
   endtask

   task automatic pop_b();
      ready_b = 1'b1;
      @(posedge clk);
      #1;
      ready_b = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      rx_a    = 1'b1;
      rx_b    = 1'b1;
      ready_a = 1'b1;
      ready_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_a_outs", {27'd0, valid_a, busy_a, fe_a, pe_a, ov_a}, 32'd0);
      chk("reset_a_data", {28'd0, data_a}, 32'd0);
      chk("reset_b_outs", {27'd0, valid_b, busy_b, fe_b, pe_b, ov_b}, 32'd0);
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 2);

      // two clean frames at one bit per clock
      base_v = cnt_vld_a;
      send_a(4'hA);
      chk("a1_valid", {31'd0, valid_a}, 32'd1);
      chk("a1_data", {28'd0, data_a}, 32'hA);
      drive(1'b0, 1'b1, 1);
      chk("a1_handshake_clears", {31'd0, valid_a}, 32'd0);
      drive(1'b0, 1'b1, 3);
      send_a(4'h7);
      chk("a2_data", {28'd0, data_a}, 32'h7);
      chk("a2_valid", {31'd0, valid_a}, 32'd1);
      drive(1'b0, 1'b1, 2);
      chk("a_no_flags", cnt_fe_a + cnt_pe_a + cnt_ov_a, 32'd0);
      chk("a_words_seen", cnt_vld_a - base_v, 32'd2);

      // stop bit low, line held low, then recovery
      base_v  = cnt_vld_a;
      base_fe = cnt_fe_a;
      drive(1'b0, 1'b0, 1);
      drive(1'b0, 1'b1, 1);
      drive(1'b0, 1'b0, 1);
      drive(1'b0, 1'b1, 1);
      drive(1'b0, 1'b1, 1);
      drive(1'b0, 1'b0, 1);
      chk("a_frame_err_pulse", {31'd0, fe_a}, 32'd1);
      chk("a_frame_err_no_valid", {31'd0, valid_a}, 32'd0);
      drive(1'b0, 1'b0, 6);
      chk("a_wait_high_busy", {31'd0, busy_a}, 32'd1);
      chk("a_frame_err_one_cycle", {31'd0, fe_a}, 32'd0);
      drive(1'b0, 1'b1, 2);
      chk("a_wait_high_exit", {31'd0, busy_a}, 32'd0);
      chk("a_frame_err_count", cnt_fe_a - base_fe, 32'd1);
      chk("a_no_word_in_wait", cnt_vld_a - base_v, 32'd0);
      send_a(4'hC);
      chk("a3_data", {28'd0, data_a}, 32'hC);
      chk("a3_valid", {31'd0, valid_a}, 32'd1);

      // even parity at 4 clocks per bit
      base_pe = cnt_pe_b;
      base_fe = cnt_fe_b;
      send_b(8'hA5, 1'b0);
      chk("b1_valid", {31'd0, valid_b}, 32'd1);
      chk("b1_data", {24'd0, data_b}, 32'hA5);
      chk("b1_no_parity_err", cnt_pe_b - base_pe, 32'd0);
      pop_b();
      chk("b1_popped", {31'd0, valid_b}, 32'd0);
      send_b(8'hA5, 1'b1);
      chk("b2_parity_err", cnt_pe_b - base_pe, 32'd1);
      chk("b2_no_valid", {31'd0, valid_b}, 32'd0);
      chk("b2_data_kept", {24'd0, data_b}, 32'hA5);
      chk("b2_no_frame_err", cnt_fe_b - base_fe, 32'd0);

      // start glitch shorter than the verify point
      base_b = cnt_fe_b + cnt_pe_b + cnt_ov_b;
      drive(1'b1, 1'b0, 1);
      chk("glitch_busy", {31'd0, busy_b}, 32'd1);
      drive(1'b1, 1'b1, 8);
      chk("glitch_idle", {31'd0, busy_b}, 32'd0);
      chk("glitch_no_valid", {31'd0, valid_b}, 32'd0);
      chk("glitch_no_flags", cnt_fe_b + cnt_pe_b + cnt_ov_b - base_b, 32'd0);

      // overrun with downstream stalled
      base_ov = cnt_ov_b;
      base_b  = cnt_fe_b + cnt_pe_b;
      send_b(8'h3C, 1'b0);
      send_b(8'hC3, 1'b0);
      chk("ovr_data_kept", {24'd0, data_b}, 32'h3C);
      chk("ovr_valid_kept", {31'd0, valid_b}, 32'd1);
      chk("ovr_pulse_count", cnt_ov_b - base_ov, 32'd1);
      chk("ovr_no_other_flags", cnt_fe_b + cnt_pe_b - base_b, 32'd0);
      pop_b();
      chk("ovr_popped", {31'd0, valid_b}, 32'd0);

      // reset in the middle of data bit 3
      drive(1'b1, 1'b0, 4);
      drive(1'b1, 1'b1, 4);
      drive(1'b1, 1'b1, 4);
      drive(1'b1, 1'b1, 4);
      rx_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      chk("rst_mid_b_outs", {27'd0, valid_b, busy_b, fe_b, pe_b, ov_b}, 32'd0);
      chk("rst_mid_b_data", {24'd0, data_b}, 32'd0);
      chk("rst_mid_a_outs", {23'd0, data_a, valid_a, busy_a, fe_a, pe_a, ov_a}, 32'd0);
      rx_b = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      base_b  = cnt_fe_b + cnt_pe_b + cnt_ov_b;
      send_b(8'h01, 1'b1);
      chk("post_rst_data", {24'd0, data_b}, 32'h01);
      chk("post_rst_valid", {31'd0, valid_b}, 32'd1);
      chk("post_rst_no_flags", cnt_fe_b + cnt_pe_b + cnt_ov_b - base_b, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
